// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger
// Purpose  : Stamps each single-cycle detector match with a free-running
//            cycle timestamp and queues it in a small show-ahead FIFO that a
//            host drains via valid/ready. Saturating counters track total
//            matches and matches lost to overflow.
// Ports    :
//   clk          in   1          rising-edge clock
//   rst          in   1          synchronous active-high reset
//   match        in   1          detector pulse, one event per high cycle
//   ev_ready     in   1          consumer accepts head entry
//   ev_valid     out  1          FIFO non-empty
//   ev_ts        out  TS_WIDTH   timestamp of oldest queued event
//   level        out  AW+1       occupancy 0..DEPTH
//   full         out  1          level == DEPTH
//   match_count  out  CNT_WIDTH  total push attempts, saturating
//   drop_count   out  CNT_WIDTH  dropped pushes, saturating
// Revision : 1.0  initial release
// ============================================================================
module match_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       match,
  input  logic                       ev_ready,
  output logic                       ev_valid,
  output logic [TS_WIDTH-1:0]        ev_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [CNT_WIDTH-1:0]       match_count,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_LW = C_AW + 1;

  logic [TS_WIDTH-1:0]  mem_q [DEPTH];
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [C_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [C_LW-1:0]      level_q, level_d;
  logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_valid = (level_q != '0);
  assign w_full  = (level_q == C_LW'(DEPTH));
  assign w_pop   = w_valid && ev_ready;
  // A pop at the same edge frees the slot, so a full FIFO can still accept.
  assign w_push_ok = match && (!w_full || w_pop);
  assign w_drop    = match && !w_push_ok;

  always_comb begin
    ts_d        = ts_q + TS_WIDTH'(1);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    match_cnt_d = match_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (w_push_ok) wr_ptr_d = wr_ptr_q + C_AW'(1);
    if (w_pop)     rd_ptr_d = rd_ptr_q + C_AW'(1);

    case ({w_push_ok, w_pop})
      2'b10:   level_d = level_q + C_LW'(1);
      2'b01:   level_d = level_q - C_LW'(1);
      default: level_d = level_q;
    endcase

    if (match && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
    if (w_drop && (drop_cnt_q != '1)) drop_cnt_d  = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      match_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      match_cnt_q <= match_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is not reset; stale contents are hidden by gating ev_ts when empty.
  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head slot is
  // being vacated this edge, so overwriting it with the new tail is safe.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) mem_q[wr_ptr_q] <= ts_q;
  end

  assign ev_valid    = w_valid;
  assign ev_ts       = w_valid ? mem_q[rd_ptr_q] : '0;
  assign level       = level_q;
  assign full        = w_full;
  assign match_count = match_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_event_logger
// Purpose  : Directed self-checking bench. Two instances share stimulus: one
//            with default parameters, one with TS_WIDTH=4 / CNT_WIDTH=3 to
//            exercise timestamp wrap and counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_match_event_logger;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic match = 1'b0;
  logic ev_ready = 1'b0;

  logic        a_valid, a_full;
  logic [15:0] a_ts;
  logic [2:0]  a_level;
  logic [7:0]  a_mc, a_dc;

  logic        b_valid, b_full;
  logic [3:0]  b_ts;
  logic [2:0]  b_level;
  logic [2:0]  b_mc, b_dc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  match_event_logger #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .match(match), .ev_ready(ev_ready),
    .ev_valid(a_valid), .ev_ts(a_ts), .level(a_level), .full(a_full),
    .match_count(a_mc), .drop_count(a_dc)
  );

  match_event_logger #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .match(match), .ev_ready(ev_ready),
    .ev_valid(b_valid), .ev_ts(b_ts), .level(b_level), .full(b_full),
    .match_count(b_mc), .drop_count(b_dc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit before checks.
  task automatic step(input logic m, input logic r, input logic rdy);
    match    = m;
    rst      = r;
    ev_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_valid", a_valid, 0);
    chk("rst_full",  a_full,  0);
    chk("rst_level", a_level, 0);
    chk("rst_mc",    a_mc,    0);
    chk("rst_dc",    a_dc,    0);
    chk("rst_ts",    a_ts,    0);

    // ---------------- single event at 6th edge (stamps 5)
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("single_valid", a_valid, 1);
    chk("single_ts",    a_ts,    5);
    chk("single_level", a_level, 1);
    chk("single_mc",    a_mc,    1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_hold_ts", a_ts, 5);
    step(1'b0, 1'b0, 1'b1);
    chk("single_pop_valid", a_valid, 0);
    chk("single_pop_level", a_level, 0);
    chk("single_pop_ts",    a_ts,    0);
    step(1'b0, 1'b0, 1'b1);
    chk("empty_ready_level", a_level, 0);
    chk("empty_ready_dc",    a_dc,    0);

    // ---------------- overflow: 6 matches, stamps 0..5, keeps 0..3
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("ovf_level", a_level, 4);
    chk("ovf_full",  a_full,  1);
    chk("ovf_dc",    a_dc,    2);
    chk("ovf_mc",    a_mc,    6);
    chk("ovf_head0", a_ts,    0);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_head1", a_ts, 1);
    chk("ovf_full_after_pop", a_full, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_head2", a_ts, 2);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_head3", a_ts, 3);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_drained", a_valid, 0);
    chk("ovf_mc_hold", a_mc, 6);

    // ---------------- full + simultaneous push/pop
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);   // stamps 0..3
    step(1'b1, 1'b0, 1'b1);                                // stamp 4 accepted, pop 0
    chk("pp_level", a_level, 4);
    chk("pp_dc",    a_dc,    0);
    chk("pp_head",  a_ts,    1);
    step(1'b1, 1'b0, 1'b0);                                // stamp 5 dropped
    chk("pp_drop_dc",   a_dc,    1);
    chk("pp_drop_head", a_ts,    1);
    chk("pp_drop_mc",   a_mc,    6);
    step(1'b0, 1'b0, 1'b1);
    chk("pp_drain2", a_ts, 2);
    step(1'b0, 1'b0, 1'b1);
    chk("pp_drain3", a_ts, 3);
    step(1'b0, 1'b0, 1'b1);
    chk("pp_tail",   a_ts, 4);
    step(1'b0, 1'b0, 1'b1);
    chk("pp_empty",  a_valid, 0);

    // ---------------- back-to-back throughput with ready high
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);   // heads 0..4
    chk("b2b_level", a_level, 1);
    chk("b2b_ts",    a_ts,    4);
    chk("b2b_dc",    a_dc,    0);
    chk("b2b_mc",    a_mc,    5);

    // ---------------- timestamp wrap (instance B, 4-bit ts)
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0);  // ts now 14
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_b_head0", b_ts, 14);
    chk("wrap_a_head0", a_ts, 14);
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_b_head1", b_ts, 15);
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_b_head2", b_ts, 0);
    chk("wrap_a_head2", a_ts, 16);
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_b_empty", b_valid, 0);

    // ---------------- saturation (instance B, 3-bit counters)
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    chk("sat_b_mc",    b_mc,    7);
    chk("sat_b_dc",    b_dc,    7);
    chk("sat_b_level", b_level, 4);
    chk("sat_b_full",  b_full,  1);
    chk("sat_a_mc",    a_mc,    12);
    chk("sat_a_dc",    a_dc,    8);

    // ---------------- reset mid-operation
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("mid_level_pre", a_level, 3);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_level", a_level, 0);
    chk("mid_valid", a_valid, 0);
    chk("mid_mc",    a_mc,    0);
    chk("mid_dc",    a_dc,    0);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_next_ts",    a_ts,    0);
    chk("mid_next_level", a_level, 1);
    chk("mid_next_mc",    a_mc,    1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial sequence detector's single-cycle `out` pulse. Each detected match is stamped with a free-running cycle timestamp and queued in a small FIFO. A host side drains the FIFO through a valid/ready handshake. Saturating counters record total matches and matches dropped because the queue was full.

## Interface
Parameters:
- `TS_WIDTH`, default 16: timestamp width; timestamp wraps modulo 2^TS_WIDTH.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.
- `CNT_WIDTH`, default 8: width of the match and drop counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `match`, in, 1: detector pulse; one event per cycle it is high.
- `ev_ready`, in, 1: consumer accepts the head entry.
- `ev_valid`, out, 1: FIFO non-empty; `ev_ts` is meaningful.
- `ev_ts`, out, TS_WIDTH: timestamp of the oldest queued event (show-ahead).
- `level`, out, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full`, out, 1: `level == DEPTH`.
- `match_count`, out, CNT_WIDTH: total matches seen, saturating.
- `drop_count`, out, CNT_WIDTH: matches discarded on overflow, saturating.

## Operation
- **Timestamp `ts` (internal):**
  - Set to 0 by reset.
  - Otherwise increments by 1 every edge and wraps from 2^TS_WIDTH−1 to 0.
  - An event captured at an edge stores the `ts` value present before that edge. The first edge after `rst` is sampled low therefore stamps 0.
- **Push:** `match` is high and `rst` is low at an edge.
  - Accepted if `!full`.
  - Also accepted if `full` and a pop occurs at the same edge, because the pop frees the slot.
  - Otherwise dropped.
- **Pop:** `ev_valid && ev_ready` at an edge.
  - `ev_ready` while `!ev_valid` has no effect.
- **Simultaneous push and pop:** `level` is unchanged.
  - When the FIFO holds exactly one entry, the new entry becomes head on the next cycle.
- **FIFO storage:** circular buffer with read and write pointers, both wrapping modulo DEPTH. `level` is tracked explicitly, not derived from pointer equality.
- **`match_count`:** increments on every push attempt, whether accepted or dropped. Holds at 2^CNT_WIDTH−1.
- **`drop_count`:** increments on every dropped push. Holds at all-ones.
- **Head stability:** `ev_ts` and `ev_valid` stay stable while `ev_valid && !ev_ready`. Pushes never alter the head entry.
- **Reset (including mid-operation):**
  - Pointers, `level`, `ts` and both counters go to 0.
  - Queued entries are discarded.
  - `match` is ignored at any edge where `rst` is high.
- **Reset values:**
  - `ev_valid`, `full`, `level`, `match_count`, `drop_count` = 0.
  - `ev_ts` = 0: storage cleared, or output gated to 0 when empty.

## Timing
- **Latency:** `match` high at edge N into an empty FIFO gives `ev_valid = 1` and `ev_ts` valid immediately after edge N. `ev_ts` is read from registers, with no combinational path from `match`.
- **Throughput:**
  - One push and one pop per cycle.
  - Back-to-back detector pulses are sustained indefinitely with `ev_ready` held high.
- **Registered-output timing:** `level`, `full`, `match_count` and `drop_count` update at the same edge as the push or pop that changes them.
- **Combinational paths:** none from `ev_ready` to any output.

## Test plan
- **Single event:** release reset, pulse `match` at the 6th edge with `ev_ready = 0`.
  - After that edge: `ev_valid = 1`, `ev_ts = 5`, `level = 1`, `match_count = 1`.
  - Then assert `ev_ready` for one edge: `ev_valid = 0`, `level = 0`.
- **Overflow:** `DEPTH = 4`, `ev_ready = 0`, `match` high for 6 consecutive edges starting at ts = 0.
  - `level = 4`, `full = 1`, `drop_count = 2`, `match_count = 6`.
  - Draining yields `ev_ts` = 0, 1, 2, 3 in order.
- **Full with simultaneous push and pop:**
  - Stimulus: fill to 4, then one edge with `match = 1` and `ev_ready = 1`.
  - Required: `level` stays 4, `drop_count` unchanged, the old head is removed, and the new tail holds that edge's ts.
  - Repeat the edge with `ev_ready = 0`: `drop_count` increments by 1.
- **Timestamp wrap:** `TS_WIDTH = 4`, `match` at edges stamped 14, 15, then 0.
  - Drained `ev_ts` sequence is 14, 15, 0.
- **Saturation:** `CNT_WIDTH = 3`, `ev_ready = 0`, 12 consecutive matches.
  - `match_count = 7`, `drop_count = 7` (8 drops saturated), `level = 4`.
- **Reset mid-operation:** with 3 entries queued and `match` high, assert `rst` for one edge.
  - After it: `level = 0`, `ev_valid = 0`, counters 0.
  - The next edge with `match = 1` stamps `ev_ts = 0`.
